// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-to-serial front end feeding the serial sequence detector.
// Optional even-parity bit per frame when BIT_SERIALIZER_PARITY_EN is defined.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

`ifdef BIT_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             ser_bit_q, ser_bit_d;
  logic             ser_valid_q, ser_valid_d;
  logic             ser_first_q, ser_first_d;
  logic             ser_last_q, ser_last_d;
  logic             busy_q, busy_d;
  logic             last_bit;
  logic             accept;
`ifdef BIT_SERIALIZER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign last_bit = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));

`ifdef BIT_SERIALIZER_PARITY_EN
  assign in_ready = (state_q == IDLE) || (state_q == PARITY);
`else
  // The next word is taken on the edge that ends the last payload bit, so frames abut.
  assign in_ready = (state_q == IDLE) || last_bit;
`endif

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    ser_bit_d   = 1'b0;
    ser_valid_d = 1'b0;
    ser_first_d = 1'b0;
    ser_last_d  = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
    parity_d    = parity_q;
`endif
    if (accept) begin
      state_d     = SHIFT;
      cnt_d       = '0;
      shreg_d     = in_data;
      ser_bit_d   = LSB_FIRST ? in_data[0] : in_data[WIDTH-1];
      ser_valid_d = 1'b1;
      ser_first_d = 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
      parity_d    = ^in_data;
`endif
    end else if ((state_q == SHIFT) && !last_bit) begin
      cnt_d       = cnt_q + CW'(1);
      // Rotating keeps the bit on air at a fixed end of the register.
      if (LSB_FIRST) begin
        shreg_d   = {shreg_q[0], shreg_q[WIDTH-1:1]};
        ser_bit_d = shreg_q[1];
      end else begin
        shreg_d   = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
        ser_bit_d = shreg_q[WIDTH-2];
      end
      ser_valid_d = 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
      ser_last_d  = 1'b0;
`else
      ser_last_d  = (cnt_q == CW'(WIDTH - 2));
`endif
`ifdef BIT_SERIALIZER_PARITY_EN
    end else if (last_bit) begin
      state_d     = PARITY;
      ser_bit_d   = parity_q;
      ser_valid_d = 1'b1;
      ser_last_d  = 1'b1;
`endif
    end else begin
      state_d     = IDLE;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      ser_bit_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_first_q <= 1'b0;
      ser_last_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      ser_bit_q   <= ser_bit_d;
      ser_valid_q <= ser_valid_d;
      ser_first_q <= ser_first_d;
      ser_last_q  <= ser_last_d;
      busy_q      <= busy_d;
`ifdef BIT_SERIALIZER_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign ser_bit   = ser_bit_q;
  assign ser_valid = ser_valid_q;
  assign ser_first = ser_first_q;
  assign ser_last  = ser_last_q;
  assign busy      = busy_q;

endmodule
